// File: rtl/serial_alu_pkg.sv
// -----------------------------------------------------------------------------
// serial_alu_pkg
//   Shared definitions for the bit-serial add/subtract sequencer.
//   - state_t   : sequencer FSM states (IDLE -> SHIFT -> DRAIN -> DONE)
//   - cnt_width : bit-counter width able to hold 0..WIDTH
// -----------------------------------------------------------------------------
package serial_alu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/serial_add_sequencer_if.sv
// -----------------------------------------------------------------------------
// serial_add_sequencer_if
//   Bundles the operand handshake, the serial adder link and the result
//   handshake of the serial add sequencer.
//   Upstream   : i_valid, o_ready, i_op_a, i_op_b, i_carry_in, i_sub
//   Adder link : o_add_a, o_add_b, o_add_c (to adder), i_add_sum, i_add_carry
//   Downstream : o_valid, i_ready, o_result, o_carry, o_overflow
//   Modports   : slave  - the sequencer itself
//                master - the surrounding environment (ALU stages + adder)
// -----------------------------------------------------------------------------
interface serial_add_sequencer_if #(
    parameter int unsigned WIDTH = 8
);
    logic             i_valid;
    logic             o_ready;
    logic [WIDTH-1:0] i_op_a;
    logic [WIDTH-1:0] i_op_b;
    logic             i_carry_in;
    logic             i_sub;
    logic             o_add_a;
    logic             o_add_b;
    logic             o_add_c;
    logic             i_add_sum;
    logic             i_add_carry;
    logic             o_valid;
    logic             i_ready;
    logic [WIDTH-1:0] o_result;
    logic             o_carry;
    logic             o_overflow;

    modport slave (
        input  i_valid, i_op_a, i_op_b, i_carry_in, i_sub,
        input  i_add_sum, i_add_carry, i_ready,
        output o_ready, o_add_a, o_add_b, o_add_c,
        output o_valid, o_result, o_carry, o_overflow
    );

    modport master (
        output i_valid, i_op_a, i_op_b, i_carry_in, i_sub,
        output i_add_sum, i_add_carry, i_ready,
        input  o_ready, o_add_a, o_add_b, o_add_c,
        input  o_valid, o_result, o_carry, o_overflow
    );

endinterface

// File: rtl/serial_shift_reg.sv
// -----------------------------------------------------------------------------
// serial_shift_reg
//   Parallel-load, shift-right-by-one register. Load has priority over shift.
//   clk_i       : clock
//   rst_ni      : asynchronous active-low reset (clears contents)
//   load_i      : load load_data_i
//   load_data_i : parallel load value
//   shift_i     : shift right by one, shift_in_i enters at the MSB
//   shift_in_i  : bit entering at the MSB
//   data_o      : current register contents
// -----------------------------------------------------------------------------
module serial_shift_reg #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_data_i,
    input  logic             shift_i,
    input  logic             shift_in_i,
    output logic [WIDTH-1:0] data_o
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;
    logic [WIDTH-1:0] shifted;

    generate
        if (WIDTH == 1) begin : g_one
            assign shifted = shift_in_i;
        end else begin : g_multi
            assign shifted = {shift_in_i, data_q[WIDTH-1:1]};
        end
    endgenerate

    always_comb begin
        data_d = data_q;
        if (load_i) begin
            data_d = load_data_i;
        end else if (shift_i) begin
            data_d = shifted;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/serial_add_sequencer.sv
// -----------------------------------------------------------------------------
// serial_add_sequencer
//   Feeds two WIDTH-bit operands LSB-first into an external bit-serial full
//   adder (registered sum/carry, 1-cycle latency), loops the adder's carry back,
//   collects the sum bits and presents result, carry-out and signed overflow.
//   Subtraction is A + ~B + 1.
//   i_clk     : clock, rising edge
//   i_reset_n : asynchronous active-low reset
//   bus       : operand handshake, adder link and result handshake (slave)
// -----------------------------------------------------------------------------
module serial_add_sequencer
    import serial_alu_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input logic                  i_clk,
    input logic                  i_reset_n,
    serial_add_sequencer_if.slave bus
);

    localparam int unsigned       CNT_W  = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0]  K_LAST = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] k_q, k_d;
    logic             c0_q, c0_d;
    logic             msb_cin_q, msb_cin_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;

    logic             load;
    logic             shift_ops;
    logic             shift_res;
    logic             add_c;
    logic             in_shift;

    logic [WIDTH-1:0] a_data;
    logic [WIDTH-1:0] b_data;
    logic [WIDTH-1:0] res_data;

    // Only bit 0 of the operand registers leaves the block; the upper bits
    // are consumed by the shift itself.
    logic unused_ops;
    assign unused_ops = ^{a_data, b_data};

    assign in_shift = (state_q == ST_SHIFT);

    // First bit takes the initial carry; later bits take the adder's
    // registered carry from the previous bit.
    always_comb begin
        add_c = 1'b0;
        if (in_shift) begin
            add_c = (k_q == '0) ? c0_q : bus.i_add_carry;
        end
    end

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        c0_d      = c0_q;
        msb_cin_d = msb_cin_q;
        carry_d   = carry_q;
        ovf_d     = ovf_q;
        load      = 1'b0;
        shift_ops = 1'b0;
        shift_res = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.i_valid) begin
                    load    = 1'b1;
                    c0_d    = bus.i_sub | bus.i_carry_in;
                    k_d     = '0;
                    carry_d = 1'b0;
                    ovf_d   = 1'b0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                shift_ops = 1'b1;
                // Adder output lags by one cycle, so bit k-1 arrives at step k.
                shift_res = (k_q != '0);
                if (k_q == K_LAST) begin
                    msb_cin_d = add_c;
                    state_d   = ST_DRAIN;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                shift_res = 1'b1;
                carry_d   = bus.i_add_carry;
                ovf_d     = msb_cin_q ^ bus.i_add_carry;
                state_d   = ST_DONE;
            end
            ST_DONE: begin
                if (bus.i_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q   <= ST_IDLE;
            k_q       <= '0;
            c0_q      <= 1'b0;
            msb_cin_q <= 1'b0;
            carry_q   <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            c0_q      <= c0_d;
            msb_cin_q <= msb_cin_d;
            carry_q   <= carry_d;
            ovf_q     <= ovf_d;
        end
    end

    serial_shift_reg #(.WIDTH(WIDTH)) u_reg_a (
        .clk_i       (i_clk),
        .rst_ni      (i_reset_n),
        .load_i      (load),
        .load_data_i (bus.i_op_a),
        .shift_i     (shift_ops),
        .shift_in_i  (1'b0),
        .data_o      (a_data)
    );

    serial_shift_reg #(.WIDTH(WIDTH)) u_reg_b (
        .clk_i       (i_clk),
        .rst_ni      (i_reset_n),
        .load_i      (load),
        .load_data_i (bus.i_op_b ^ {WIDTH{bus.i_sub}}),
        .shift_i     (shift_ops),
        .shift_in_i  (1'b0),
        .data_o      (b_data)
    );

    serial_shift_reg #(.WIDTH(WIDTH)) u_reg_res (
        .clk_i       (i_clk),
        .rst_ni      (i_reset_n),
        .load_i      (load),
        .load_data_i ('0),
        .shift_i     (shift_res),
        .shift_in_i  (bus.i_add_sum),
        .data_o      (res_data)
    );

    assign bus.o_ready    = (state_q == ST_IDLE);
    assign bus.o_valid    = (state_q == ST_DONE);
    assign bus.o_add_a    = in_shift & a_data[0];
    assign bus.o_add_b    = in_shift & b_data[0];
    assign bus.o_add_c    = add_c;
    assign bus.o_result   = res_data;
    assign bus.o_carry    = carry_q;
    assign bus.o_overflow = ovf_q;

endmodule

// File: tb/tb_serial_add_sequencer.sv
module tb_serial_add_sequencer;

    localparam int unsigned W = 8;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    serial_add_sequencer_if #(.WIDTH(W)) bus ();

    serial_add_sequencer #(.WIDTH(W)) dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .bus       (bus)
    );

    // Bit-serial full adder with registered sum and carry.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.i_add_sum   <= 1'b0;
            bus.i_add_carry <= 1'b0;
        end else begin
            bus.i_add_sum   <= bus.o_add_a ^ bus.o_add_b ^ bus.o_add_c;
            bus.i_add_carry <= (bus.o_add_a & bus.o_add_b) | (bus.o_add_a & bus.o_add_c) |
                               (bus.o_add_b & bus.o_add_c);
        end
    end

    typedef struct {
        logic [W-1:0] res;
        logic         c;
        logic         v;
        int unsigned  acc;
    } exp_t;

    exp_t        sbq[$];
    int unsigned checks   = 0;
    int unsigned failures = 0;
    int unsigned cyc      = 0;
    int unsigned last_hs  = 0;
    logic        prev_v   = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic cin, input logic sub);
        logic [W:0]   s;
        logic [W-1:0] bb;
        logic         v;
        bb = sub ? ~b : b;
        s  = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, (sub ? 1'b1 : cin)};
        v  = (a[W-1] == bb[W-1]) && (s[W-1] != a[W-1]);
        return {v, s[W], s[W-1:0]};
    endfunction

    // Monitor: checks latency on o_valid rise and pops/compares on handshake.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (bus.o_valid && !prev_v) begin
                if (sbq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_valid: got o_valid=1 expected no result pending (t=%0t)", $time);
                end else begin
                    check("latency", cyc - sbq[0].acc, W + 1);
                end
            end
            if (bus.o_valid && bus.i_ready && sbq.size() != 0) begin
                e = sbq.pop_front();
                check("result",   bus.o_result,   e.res);
                check("carry",    bus.o_carry,    e.c);
                check("overflow", bus.o_overflow, e.v);
                last_hs = cyc + 1;
            end
            prev_v = bus.o_valid;
        end
    end

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        input logic sub, input logic [W-1:0] er, input logic ec,
                        input logic ev, input bit hold, input bit b2b);
        int unsigned n;
        exp_t e;
        @(negedge clk);
        bus.i_op_a     = a;
        bus.i_op_b     = b;
        bus.i_carry_in = cin;
        bus.i_sub      = sub;
        bus.i_valid    = 1'b1;
        n = 0;
        while (!bus.o_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!bus.o_ready) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: got o_ready=0 expected 1 within 40 cycles");
            bus.i_valid = 1'b0;
            return;
        end
        e.res = er;
        e.c   = ec;
        e.v   = ev;
        e.acc = cyc + 1;
        sbq.push_back(e);
        if (b2b) check("back_to_back_gap", cyc + 1 - last_hs, 1);
        @(negedge clk);
        if (!hold) bus.i_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int unsigned n;
        n = 0;
        while ((sbq.size() != 0 || !bus.o_ready) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (sbq.size() != 0 || !bus.o_ready) begin
            checks++;
            failures++;
            $display("FAIL idle_timeout: got pending=%0d expected 0", sbq.size());
            sbq.delete();
        end
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [W+1:0] m;
        logic [W-1:0] ra, rb;
        logic         rc, rs;
        int unsigned  n;

        rst_n          = 1'b0;
        bus.i_valid    = 1'b0;
        bus.i_op_a     = '0;
        bus.i_op_b     = '0;
        bus.i_carry_in = 1'b0;
        bus.i_sub      = 1'b0;
        bus.i_ready    = 1'b1;
        #1;
        check("rst_ready",    bus.o_ready,    1);
        check("rst_valid",    bus.o_valid,    0);
        check("rst_result",   bus.o_result,   0);
        check("rst_carry",    bus.o_carry,    0);
        check("rst_overflow", bus.o_overflow, 0);
        check("rst_add_abc",  {bus.o_add_a, bus.o_add_b, bus.o_add_c}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors: a, b, cin, sub -> result, carry, overflow
        send(8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0, 1'b0, 1'b0);
        send(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        send(8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0, 1'b0);
        send(8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b0, 1'b0);
        send(8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0, 1'b0);
        send(8'h10, 8'h20, 1'b1, 1'b0, 8'h31, 1'b0, 1'b0, 1'b0, 1'b0);
        send(8'h10, 8'h10, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        wait_idle();

        // Downstream stall in DONE with a competing upstream request.
        bus.i_ready = 1'b0;
        send(8'h3C, 8'h0A, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0, 1'b0, 1'b0);
        n = 0;
        while (!bus.o_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        bus.i_op_a  = 8'hFF;
        bus.i_op_b  = 8'hFF;
        bus.i_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("hold_valid",  bus.o_valid,  1);
            check("hold_result", bus.o_result, 8'h46);
            check("hold_carry",  bus.o_carry,  0);
            check("hold_ready",  bus.o_ready,  0);
        end
        bus.i_valid = 1'b0;
        bus.i_ready = 1'b1;
        wait_idle();

        // Reset asserted mid-operation at bit step k=3.
        send(8'hAA, 8'h55, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        #1;
        rst_n = 1'b0;
        sbq.delete();
        #1;
        check("abort_valid",  bus.o_valid,  0);
        check("abort_ready",  bus.o_ready,  1);
        check("abort_result", bus.o_result, 0);
        @(negedge clk);
        rst_n = 1'b1;
        send(8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0, 1'b0, 1'b0);

        // Back-to-back random traffic with i_valid held high.
        for (int unsigned i = 0; i < 200; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
            rs = 1'($urandom);
            m  = model(ra, rb, rc, rs);
            send(ra, rb, rc, rs, m[W-1:0], m[W], m[W+1], (i != 199), (i != 0));
        end
        wait_idle();
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
